br_issue_arbiter: RTL and testbench
===================================

Name: br_issue_arbiter

Overview:
- Issue-stage controller for the branch functional unit (FUBR).
- Arbitrates between two strictly ordered requesters: the branch RS (port 0) and the jump/link RS (port 1). The grant goes to the uop that is older in ROB order.
- Returns the per-port Issued_Valid confirmation that removes the granted entry from its RS.
- Holds the granted uop in a one-entry issue register until FUBR accepts it. Kills, killmask updates, stall and flush are all applied to the held uop.

Parameters:
- ENTRY_LEN, `RS_BR_LEN, width of one RS entry.
- ROB_IDX_LEN, $clog2(`ROB_DEPTH), width of the ROB index without the wrap bit.
- SPEC_LEN, `SPEC_STATES, width of the killmask and speculation tag.
- CNT_LEN, 32, width of the per-port grant counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Stall  in  1  freezes all state and suppresses grants
- Flush  in  1  clears the issue register; counters are kept
- Kill_Enable  in  1  branch mispredict
- Update_KillMask  in  1  correctly predicted branch resolved
- FUBR_SpecTag  in  SPEC_LEN  one-hot tag of the resolving branch
- ROB_Head  in  ROB_IDX_LEN+1  ROB head index including the wrap bit
- Req_Entry0  in  ENTRY_LEN  branch RS issue request entry
- Req_Valid0  in  1  branch RS request is valid
- Req_Entry1  in  ENTRY_LEN  jump RS issue request entry
- Req_Valid1  in  1  jump RS request is valid
- Issued_Valid0  out  1  grant confirmation to the branch RS
- Issued_Valid1  out  1  grant confirmation to the jump RS
- FU_Ready  in  1  FUBR accepts the uop this cycle
- FU_Entry  out  ENTRY_LEN  uop presented to FUBR
- FU_Valid  out  1  FU_Entry is valid
- Grant_Cnt0  out  CNT_LEN  number of port-0 grants
- Grant_Cnt1  out  CNT_LEN  number of port-1 grants

Behaviour:
- Reset values: FU_Valid=0, FU_Entry=0, Grant_Cnt0=0, Grant_Cnt1=0, Issued_Valid0/1=0. State is EMPTY.
- FSM has two states:
  - EMPTY: issue register invalid.
  - HOLD: issue register valid.
  - FU_Valid is 1 exactly when the state is HOLD.
- Request liveness: a request is live when Req_ValidN=1 and it is not dying this cycle. A request is dying when Kill_Enable=1 and (Req_EntryN[`RS_KILLMASK] & FUBR_SpecTag) is nonzero.
- Slot free (combinational): Stall=0 and Flush=0 and (EMPTY, or HOLD with FU_Ready=1, or HOLD with the held uop being killed this cycle).
- Age and selection:
  - age_N = (Req_EntryN[`RS_ROBIDX] - ROB_Head) mod 2^(ROB_IDX_LEN+1).
  - The smaller age wins. Equal ages are illegal; port 0 wins them.
  - If only one request is live, that request wins.
- Issued_ValidN is combinational, asserted in the same cycle as the request. It is 1 only for the winner, and only when the slot is free. At most one of the two is 1 per cycle.
- On a grant, at the clock edge:
  - FU_Entry <= winning entry. If Update_KillMask=1, the `RS_KILLMASK field is written as mask & ~FUBR_SpecTag.
  - State goes to HOLD.
  - Grant_CntN increments, wrapping at 2^CNT_LEN.
  - Grant-to-FU_Valid latency is 1 cycle.
- HOLD, no grant:
  - If FU_Ready=1, go to EMPTY.
  - Else if Kill_Enable=1 and the held killmask hits FUBR_SpecTag, go to EMPTY. FU_Valid drops on the next cycle.
  - Else if Update_KillMask=1, clear the FUBR_SpecTag bit in the held killmask.
  - Otherwise hold, with FU_Entry stable.
- Simultaneous FU_Ready and a new grant: back-to-back issue, state stays HOLD. Sustained throughput is 1 uop per cycle.
- Flush=1: next state EMPTY. No grant and no counter change. Flush takes priority over Stall.
- Stall=1 (no Flush): all registers hold and Issued_Valid0/1=0. FU_Ready is ignored, so the FU must not consume a uop during Stall.
- rst mid-operation: same as reset. The held uop is dropped and both counters are cleared.
- ROB wrap-around: the modular age handles the index crossing 2^(ROB_IDX_LEN+1)-1 to 0.

Decomposition:
- Shared package / core_defines.vh: `RS_ROBIDX, `RS_KILLMASK and `RS_VALID field macros, `ROB_DEPTH, `SPEC_STATES.
- One natural sub-module: rob_age_compare. Its inputs are two ROB indices and ROB_Head; its output is older_is_a. It is reusable by other RS issue arbiters.

Test Plan:
- ROB_Head=0, Req0 ROBIDX=5, Req1 ROBIDX=3, both valid, EMPTY -> Issued_Valid1=1, Issued_Valid0=0. Next cycle FU_Valid=1, FU_Entry=Req1, Grant_Cnt1=1.
- Wrap: ROB_HEAD=62 with 6-bit index, Req0 ROBIDX=63, Req1 ROBIDX=1 -> port 0 granted (age 1 vs 3).
- HOLD with FU_Ready=0 for 3 cycles, then FU_Ready=1 while Req0 is valid -> no Issued_Valid for 3 cycles. On the 4th cycle Issued_Valid0=1 and the next uop is latched back-to-back.
- HOLD, held killmask=0b0100, Kill_Enable=1, FUBR_SpecTag=0b0100, FU_Ready=0 -> FU_Valid=0 next cycle. A live Req0 with killmask 0 is granted in the same cycle.
- HOLD, held killmask=0b0110, Update_KillMask=1, SpecTag=0b0010 -> held killmask becomes 0b0100. A subsequent kill with tag 0b0010 does not drop it.
- Stall=1 with both requests valid for 2 cycles -> no Issued_Valid and no state change. Flush during HOLD -> FU_Valid=0 next cycle, counters unchanged. rst -> all outputs 0.

Source files
------------

// File: rtl/br_issue_arbiter_pkg.sv
// br_issue_arbiter_pkg: core widths and branch RS entry field layout shared by issue arbiters.
package br_issue_arbiter_pkg;
  localparam int ROB_DEPTH   = 32;
  localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);
  localparam int SPEC_STATES = 4;
  localparam int RS_BR_LEN   = 16;
  // entry = {payload[4:0], valid, killmask[3:0], robidx incl. wrap bit[5:0]}
  localparam int ROBIDX_LO = 0;
  localparam int ROBIDX_HI = ROB_IDX_LEN;
  localparam int KM_LO     = ROBIDX_HI + 1;
  localparam int KM_HI     = KM_LO + SPEC_STATES - 1;
  localparam int VALID_BIT = KM_HI + 1;
  function automatic logic km_hit(input logic [SPEC_STATES-1:0] km, input logic [SPEC_STATES-1:0] tag);
    return |(km & tag);
  endfunction
endpackage

// File: rtl/br_issue_arbiter_rob_age_compare.sv
// rob_age_compare: picks the older of two ROB indices relative to the head, wrap-safe.
module rob_age_compare #(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx_a,
  input  logic [IDX_W-1:0] idx_b,
  input  logic [IDX_W-1:0] head,
  output logic             older_is_a
);
  logic [IDX_W-1:0] age_a, age_b;
  always_comb begin
    age_a      = idx_a - head;
    age_b      = idx_b - head;
    older_is_a = age_a <= age_b;
  end
endmodule

// File: rtl/br_issue_arbiter.sv
// br_issue_arbiter: age-ordered grant between branch and jump RS into a one-entry FUBR issue register.
module br_issue_arbiter
  import br_issue_arbiter_pkg::*;
#(
  parameter int ENTRY_LEN   = RS_BR_LEN,
  parameter int ROB_IDX_LEN = br_issue_arbiter_pkg::ROB_IDX_LEN,
  parameter int SPEC_LEN    = SPEC_STATES,
  parameter int CNT_LEN     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   Kill_Enable,
  input  logic                   Update_KillMask,
  input  logic [SPEC_LEN-1:0]    FUBR_SpecTag,
  input  logic [ROB_IDX_LEN:0]   ROB_Head,
  input  logic [ENTRY_LEN-1:0]   Req_Entry0,
  input  logic                   Req_Valid0,
  input  logic [ENTRY_LEN-1:0]   Req_Entry1,
  input  logic                   Req_Valid1,
  output logic                   Issued_Valid0,
  output logic                   Issued_Valid1,
  input  logic                   FU_Ready,
  output logic [ENTRY_LEN-1:0]   FU_Entry,
  output logic                   FU_Valid,
  output logic [CNT_LEN-1:0]     Grant_Cnt0,
  output logic [CNT_LEN-1:0]     Grant_Cnt1
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [ENTRY_LEN-1:0] fu_entry_q, fu_entry_d, win;
  logic [CNT_LEN-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 live0, live1, older0, sel0, held_kill, slot_free;
  rob_age_compare #(.IDX_W(ROB_IDX_LEN + 1)) u_age (
    .idx_a      (Req_Entry0[ROBIDX_HI:ROBIDX_LO]),
    .idx_b      (Req_Entry1[ROBIDX_HI:ROBIDX_LO]),
    .head       (ROB_Head),
    .older_is_a (older0)
  );
  always_comb begin
    live0         = Req_Valid0 && !(Kill_Enable && km_hit(Req_Entry0[KM_HI:KM_LO], FUBR_SpecTag));
    live1         = Req_Valid1 && !(Kill_Enable && km_hit(Req_Entry1[KM_HI:KM_LO], FUBR_SpecTag));
    held_kill     = state_q == HOLD && Kill_Enable && km_hit(fu_entry_q[KM_HI:KM_LO], FUBR_SpecTag);
    slot_free     = !Stall && !Flush && (state_q == EMPTY || FU_Ready || held_kill);
    sel0          = live0 && (!live1 || older0);
    Issued_Valid0 = slot_free && sel0;
    Issued_Valid1 = slot_free && live1 && !sel0;
    win           = sel0 ? Req_Entry0 : Req_Entry1;
    state_d       = state_q;
    fu_entry_d    = fu_entry_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    if (Flush) state_d = EMPTY;
    else if (Issued_Valid0 || Issued_Valid1) begin
      state_d    = HOLD;
      fu_entry_d = win;
      if (Update_KillMask) fu_entry_d[KM_HI:KM_LO] = win[KM_HI:KM_LO] & ~FUBR_SpecTag;
      cnt0_d     = cnt0_q + {{(CNT_LEN-1){1'b0}}, Issued_Valid0};
      cnt1_d     = cnt1_q + {{(CNT_LEN-1){1'b0}}, Issued_Valid1};
    end else if (!Stall && state_q == HOLD) begin
      if (FU_Ready || held_kill) state_d = EMPTY;
      else if (Update_KillMask) fu_entry_d[KM_HI:KM_LO] = fu_entry_q[KM_HI:KM_LO] & ~FUBR_SpecTag;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      fu_entry_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      fu_entry_q <= fu_entry_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end
  assign FU_Valid   = state_q == HOLD;
  assign FU_Entry   = fu_entry_q;
  assign Grant_Cnt0 = cnt0_q;
  assign Grant_Cnt1 = cnt1_q;
endmodule

// File: tb/tb_br_issue_arbiter.sv
// tb_br_issue_arbiter: directed scoreboard bench for the FUBR issue arbiter.
module tb_br_issue_arbiter;
  logic        clk = 0, rst = 1, Stall = 0, Flush = 0, Kill_Enable = 0, Update_KillMask = 0;
  logic [3:0]  FUBR_SpecTag = 0;
  logic [5:0]  ROB_Head = 0;
  logic [15:0] Req_Entry0 = 0, Req_Entry1 = 0;
  logic        Req_Valid0 = 0, Req_Valid1 = 0, FU_Ready = 0;
  logic        Issued_Valid0, Issued_Valid1, FU_Valid;
  logic [15:0] FU_Entry;
  logic [31:0] Grant_Cnt0, Grant_Cnt1;
  int          total = 0, bad = 0;
  int          c0 = 0, c1 = 0;
  logic [15:0] q[$];
  logic [15:0] cur = 0;
  br_issue_arbiter dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Kill_Enable(Kill_Enable),
    .Update_KillMask(Update_KillMask), .FUBR_SpecTag(FUBR_SpecTag), .ROB_Head(ROB_Head),
    .Req_Entry0(Req_Entry0), .Req_Valid0(Req_Valid0), .Req_Entry1(Req_Entry1), .Req_Valid1(Req_Valid1),
    .Issued_Valid0(Issued_Valid0), .Issued_Valid1(Issued_Valid1), .FU_Ready(FU_Ready),
    .FU_Entry(FU_Entry), .FU_Valid(FU_Valid), .Grant_Cnt0(Grant_Cnt0), .Grant_Cnt1(Grant_Cnt1)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mk(input logic [4:0] p, input logic [3:0] km, input logic [5:0] r);
    return {p, 1'b1, km, r};
  endfunction
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", t, o, e);
    end
  endtask
  task automatic cyc(input logic [15:0] exp_win, input bit e_iv0, input bit e_iv1, input bit e_fv);
    #1;
    chk("iv0", {31'b0, Issued_Valid0}, {31'b0, e_iv0});
    chk("iv1", {31'b0, Issued_Valid1}, {31'b0, e_iv1});
    if (e_iv0 || e_iv1) q.push_back(exp_win);
    if (e_iv0) c0++;
    if (e_iv1) c1++;
    @(posedge clk); #1;
    if ((e_iv0 || e_iv1) && q.size() > 0) cur = q.pop_front();
    chk("fu_valid", {31'b0, FU_Valid}, {31'b0, e_fv});
    if (e_fv) chk("fu_entry", {16'b0, FU_Entry}, {16'b0, cur});
    chk("cnt0", Grant_Cnt0, c0);
    chk("cnt1", Grant_Cnt1, c1);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fv", {31'b0, FU_Valid}, 0);
    chk("rst_entry", {16'b0, FU_Entry}, 0);
    chk("rst_cnt0", Grant_Cnt0, 0);
    chk("rst_cnt1", Grant_Cnt1, 0);
    @(negedge clk); rst = 0;
    // older request on port 1 wins
    Req_Entry0 = mk(5'd1, 4'b0000, 6'd5); Req_Entry1 = mk(5'd2, 4'b0000, 6'd3);
    Req_Valid0 = 1; Req_Valid1 = 1;
    cyc(Req_Entry1, 0, 1, 1);
    // held three cycles, then back-to-back issue of port 0
    Req_Valid1 = 0; Req_Entry0 = mk(5'd3, 4'b0000, 6'd4);
    repeat (3) cyc(16'h0, 0, 0, 1);
    FU_Ready = 1;
    cyc(Req_Entry0, 1, 0, 1);
    Req_Valid0 = 0;
    cyc(16'h0, 0, 0, 0);
    // ROB wrap: age 1 vs 3
    FU_Ready = 0; ROB_Head = 6'd62;
    Req_Entry0 = mk(5'd4, 4'b0000, 6'd63); Req_Entry1 = mk(5'd5, 4'b0000, 6'd1);
    Req_Valid0 = 1; Req_Valid1 = 1;
    cyc(Req_Entry0, 1, 0, 1);
    // load killmask 0100, then kill it with nothing behind
    Req_Valid1 = 0; FU_Ready = 1; Req_Entry0 = mk(5'd6, 4'b0100, 6'd0);
    cyc(Req_Entry0, 1, 0, 1);
    Req_Valid0 = 0; FU_Ready = 0; Kill_Enable = 1; FUBR_SpecTag = 4'b0100;
    cyc(16'h0, 0, 0, 0);
    // kill of held uop frees the slot for a live request in the same cycle
    Kill_Enable = 0; Req_Valid0 = 1;
    cyc(Req_Entry0, 1, 0, 1);
    Kill_Enable = 1; Req_Entry0 = mk(5'd7, 4'b0000, 6'd1);
    cyc(Req_Entry0, 1, 0, 1);
    // killmask update on held uop, then a kill on the cleared bit misses
    Kill_Enable = 0; FU_Ready = 1; Req_Entry0 = mk(5'd8, 4'b0110, 6'd2);
    cyc(Req_Entry0, 1, 0, 1);
    Req_Valid0 = 0; FU_Ready = 0; Update_KillMask = 1; FUBR_SpecTag = 4'b0010;
    cur = mk(5'd8, 4'b0100, 6'd2);
    cyc(16'h0, 0, 0, 1);
    Update_KillMask = 0; Kill_Enable = 1;
    cyc(16'h0, 0, 0, 1);
    // stall: nothing moves even with FU_Ready
    Kill_Enable = 0; Stall = 1; FU_Ready = 1;
    Req_Entry0 = mk(5'd9, 4'b0000, 6'd3); Req_Entry1 = mk(5'd10, 4'b0000, 6'd4);
    Req_Valid0 = 1; Req_Valid1 = 1;
    repeat (2) cyc(16'h0, 0, 0, 1);
    // flush beats stall and keeps counters
    Flush = 1;
    cyc(16'h0, 0, 0, 0);
    Flush = 0; Stall = 0;
    cyc(Req_Entry0, 1, 0, 1);
    // grant with simultaneous killmask update writes the cleared mask
    Req_Valid0 = 0; Update_KillMask = 1; FUBR_SpecTag = 4'b1000;
    Req_Entry1 = mk(5'd11, 4'b1010, 6'd5);
    cyc(mk(5'd11, 4'b0010, 6'd5), 0, 1, 1);
    Update_KillMask = 0; Req_Valid1 = 0; FU_Ready = 0;
    rst = 1; c0 = 0; c1 = 0;
    @(posedge clk); #1;
    chk("rst2_fv", {31'b0, FU_Valid}, 0);
    chk("rst2_entry", {16'b0, FU_Entry}, 0);
    chk("rst2_cnt0", Grant_Cnt0, c0);
    chk("rst2_cnt1", Grant_Cnt1, c1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
